// File: rtl/ufib_pkg.sv
// Shared UFI bus definitions: default bus widths, location of the
// command-valid flag inside the address word, and the write-FIFO FSM
// state encoding.
package ufib_pkg;

  localparam int UFI_DQ_W    = 16;
  localparam int UFI_ADRS_W  = 32;
  // The command-valid flag is the MSB of the address word.
  localparam int UFI_VLD_BIT = UFI_ADRS_W - 1;

  typedef enum logic [1:0] {
    sIdle  = 2'd0,
    sSend  = 2'd1,
    sFlush = 2'd2
  } ufi_wr_state_e;

  // Valid-bit index for an address bus of arbitrary width. It keeps the
  // same offset from the MSB as the default bus does.
  function automatic int ufi_vld_bit(input int adrs_w);
    return adrs_w - (UFI_ADRS_W - UFI_VLD_BIT);
  endfunction

endpackage

// File: rtl/ufi_fifo_mem.sv
// Simple dual-port storage for the UFI write FIFO.
// The write port is registered. The read port is asynchronous, so the
// head entry can be loaded straight into the output register.
// Ports: iSCLK clock; iWe/iWAdrs/iWd write port; iRAdrs/oRd read port.
// The array is not reset, so its contents are don't-care until written.
module ufi_fifo_mem #(
  parameter  int pWidth = 47,
  parameter  int pDepth = 16,
  localparam int AW     = $clog2(pDepth)
) (
  input  logic              iSCLK,
  input  logic              iWe,
  input  logic [AW-1:0]     iWAdrs,
  input  logic [pWidth-1:0] iWd,
  input  logic [AW-1:0]     iRAdrs,
  output logic [pWidth-1:0] oRd
);

  logic [pWidth-1:0] mem_q [pDepth];

  always_ff @(posedge iSCLK) begin
    if (iWe) mem_q[iWAdrs] <= iWd;
  end

  assign oRd = mem_q[iRAdrs];

endmodule

// File: rtl/ufi_wr_fifo.sv
// UFI write FIFO. It buffers {address, data} pushes from the MCB CSR path
// and presents them one at a time on the UFIB master port as a
// valid/ready handshake. A transfer happens when valid & iMUfiRdy.
//
// Ports:
//   iSCLK, iSRST         clock; synchronous active-high reset
//   iWd, iAdrs, iWe      producer push port
//   iFlush               discard everything buffered or pending
//   oMUfiWd, oMUfiAdrs   output register; oMUfiAdrs MSB is the valid flag
//   iMUfiRdy             UFIB accept
//   oFull, oEmpty,       occupancy, counting the memory entries plus
//   oLevel               the output register
//   oOvf                 one-cycle pulse, the cycle after a dropped push
//   oOvfCnt              saturating drop counter; present only when
//                        UFI_WR_FIFO_STATS_EN is defined
//
// The output register is the head of the queue. A push into an empty
// queue, or a push while the only word is leaving, loads the output
// register directly. Every other push goes to the memory.
module ufi_wr_fifo
  import ufib_pkg::*;
#(
  parameter int pUfiDqBusWidth   = UFI_DQ_W,
  parameter int pUfiAdrsBusWidth = UFI_ADRS_W,
  parameter int pFifoDepth       = 16
) (
  input  logic                            iSCLK,
  input  logic                            iSRST,
  input  logic [pUfiDqBusWidth-1:0]       iWd,
  input  logic [pUfiAdrsBusWidth-2:0]     iAdrs,
  input  logic                            iWe,
  input  logic                            iFlush,
  output logic [pUfiDqBusWidth-1:0]       oMUfiWd,
  output logic [pUfiAdrsBusWidth-1:0]     oMUfiAdrs,
  input  logic                            iMUfiRdy,
  output logic                            oFull,
  output logic                            oEmpty,
  output logic [$clog2(pFifoDepth):0]     oLevel,
  output logic                            oOvf
`ifdef UFI_WR_FIFO_STATS_EN
  ,
  output logic [15:0]                     oOvfCnt
`endif
);

  localparam int AW  = $clog2(pFifoDepth);
  localparam int PW  = AW + 1;
  localparam int AJW = pUfiAdrsBusWidth - 1;
  localparam int EW  = pUfiDqBusWidth + AJW;
  localparam int VLD = ufi_vld_bit(pUfiAdrsBusWidth);

  ufi_wr_state_e           state_q, state_d;
  logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [pUfiDqBusWidth-1:0] out_wd_q, out_wd_d;
  logic [AJW-1:0]          out_adrs_q, out_adrs_d;
  logic                    ovf_q, ovf_d;

  logic                    out_vld, xfer, full, push_ok, mem_we;
  logic [PW-1:0]           mem_cnt, level;
  logic [EW-1:0]           mem_rd;

  ufi_fifo_mem #(
    .pWidth (EW),
    .pDepth (pFifoDepth)
  ) u_mem (
    .iSCLK  (iSCLK),
    .iWe    (mem_we),
    .iWAdrs (wptr_q[AW-1:0]),
    .iWd    ({iWd, iAdrs}),
    .iRAdrs (rptr_q[AW-1:0]),
    .oRd    (mem_rd)
  );

  assign out_vld = (state_q == sSend);
  assign xfer    = out_vld & iMUfiRdy;
  // The extra MSB on each pointer makes wptr - rptr range over 0..depth.
  assign mem_cnt = wptr_q - rptr_q;
  assign level   = mem_cnt + PW'(out_vld);
  assign full    = (level == PW'(pFifoDepth));

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    out_wd_d   = out_wd_q;
    out_adrs_d = out_adrs_q;
    ovf_d      = 1'b0;
    mem_we     = 1'b0;
    push_ok    = 1'b0;
    if (iFlush) begin
      state_d = sFlush;
      wptr_d  = '0;
      rptr_d  = '0;
    end else if (state_q == sFlush) begin
      state_d = sIdle;
    end else begin
      // When full, a push still fits if the head leaves in the same cycle.
      push_ok = iWe & (~full | xfer);
      ovf_d   = iWe & ~push_ok;
      if (~out_vld | xfer) begin
        if (mem_cnt != '0) begin
          {out_wd_d, out_adrs_d} = mem_rd;
          rptr_d  = rptr_q + PW'(1);
          state_d = sSend;
          if (push_ok) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + PW'(1);
          end
        end else if (push_ok) begin
          // The memory is empty, so the new word goes straight to the output.
          out_wd_d   = iWd;
          out_adrs_d = iAdrs;
          state_d    = sSend;
        end else begin
          state_d = sIdle;
        end
      end else if (push_ok) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge iSCLK) begin
    if (iSRST) begin
      state_q    <= sIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      out_wd_q   <= '0;
      out_adrs_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      out_wd_q   <= out_wd_d;
      out_adrs_q <= out_adrs_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    oMUfiAdrs = '0;
    if (out_vld) begin
      oMUfiAdrs[VLD-1:0] = out_adrs_q;
      oMUfiAdrs[VLD]     = 1'b1;
    end
  end

  assign oMUfiWd = out_wd_q;
  assign oLevel  = level;
  assign oFull   = full;
  assign oEmpty  = (level == '0);
  assign oOvf    = ovf_q;

`ifdef UFI_WR_FIFO_STATS_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (iFlush) ovf_cnt_d = '0;
    else if (ovf_d && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge iSCLK) begin
    if (iSRST) ovf_cnt_q <= '0;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  assign oOvfCnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_ufi_wr_fifo.sv
// Self-checking bench for ufi_wr_fifo. It uses directed scenarios and a
// randomized run, all compared against a queue-based reference model.
module tb_ufi_wr_fifo;

  localparam int DEPTH = 16;

  logic        iSCLK = 1'b0;
  logic        iSRST = 1'b0;
  logic [15:0] iWd = '0;
  logic [30:0] iAdrs = '0;
  logic        iWe = 1'b0, iFlush = 1'b0, iMUfiRdy = 1'b0;
  logic [15:0] oMUfiWd;
  logic [31:0] oMUfiAdrs;
  logic        oFull, oEmpty, oOvf;
  logic [4:0]  oLevel;
`ifdef UFI_WR_FIFO_STATS_EN
  logic [15:0] oOvfCnt;
`endif

  ufi_wr_fifo #(.pUfiDqBusWidth(16), .pUfiAdrsBusWidth(32), .pFifoDepth(DEPTH)) dut (
    .iSCLK(iSCLK), .iSRST(iSRST), .iWd(iWd), .iAdrs(iAdrs), .iWe(iWe),
    .iFlush(iFlush), .oMUfiWd(oMUfiWd), .oMUfiAdrs(oMUfiAdrs),
    .iMUfiRdy(iMUfiRdy), .oFull(oFull), .oEmpty(oEmpty), .oLevel(oLevel),
    .oOvf(oOvf)
`ifdef UFI_WR_FIFO_STATS_EN
    , .oOvfCnt(oOvfCnt)
`endif
  );

  always #5 iSCLK = ~iSCLK;

  int nchk = 0, nerr = 0;

  // RAMBlock model: the UFIB slave writes every accepted word to its address.
  logic [15:0] rMem [256];
  always @(posedge iSCLK)
    if (oMUfiAdrs[31] && iMUfiRdy) rMem[oMUfiAdrs[7:0]] <= oMUfiWd;

  // Reference model: an ordered queue of words. Its head is the word on
  // the output port.
  typedef struct packed { logic [15:0] wd; logic [30:0] adrs; } ent_t;
  ent_t mq[$];
  bit   m_ovf, m_fpend;
  int   m_cnt;

  // Drives one cycle of inputs, then advances the model at the clock edge.
  task automatic drive(input logic we, input logic [15:0] wd, input logic [30:0] adrs,
                       input logic rdy, input logic fl);
    int sz; bit xf, ok;
    iWe = we; iWd = wd; iAdrs = adrs; iMUfiRdy = rdy; iFlush = fl;
    @(posedge iSCLK);
    sz = mq.size();
    if (iSRST) begin
      mq.delete(); m_ovf = 0; m_cnt = 0; m_fpend = 0;
    end else if (fl) begin
      mq.delete(); m_ovf = 0; m_cnt = 0; m_fpend = 1;
    end else if (m_fpend) begin
      m_fpend = 0; m_ovf = 0;
    end else begin
      xf = (sz > 0) && rdy;
      if (xf) void'(mq.pop_front());
      ok = we && (sz < DEPTH || xf);
      m_ovf = we && !ok;
      if (m_ovf && m_cnt < 65535) m_cnt++;
      if (ok) mq.push_back('{wd, adrs});
    end
    #1;
  endtask

  task automatic do_reset();
    iSRST = 1'b1;
    drive(0, '0, '0, 0, 0);
    drive(0, '0, '0, 0, 0);
    iSRST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nchk++; if (oMUfiWd !== 16'h0) begin nerr++; $display("FAIL reset_wd got=%h exp=0", oMUfiWd); end
    nchk++; if (oMUfiAdrs !== 32'h0) begin nerr++; $display("FAIL reset_adrs got=%h exp=0", oMUfiAdrs); end
    nchk++; if ({oEmpty, oFull, oOvf} !== 3'b100) begin nerr++; $display("FAIL reset_flags got=%b exp=100", {oEmpty, oFull, oOvf}); end
    nchk++; if (oLevel !== 5'd0) begin nerr++; $display("FAIL reset_level got=%0d exp=0", oLevel); end
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 16'h1234, 31'h10, 1, 0);
    nchk++; if (oMUfiAdrs !== 32'h8000_0010) begin nerr++; $display("FAIL single_adrs got=%h exp=80000010", oMUfiAdrs); end
    nchk++; if (oMUfiWd !== 16'h1234) begin nerr++; $display("FAIL single_wd got=%h exp=1234", oMUfiWd); end
    drive(0, '0, '0, 1, 0);
    nchk++; if (oMUfiAdrs !== 32'h0 || oEmpty !== 1'b1) begin nerr++; $display("FAIL single_after got=%h/%b exp=0/1", oMUfiAdrs, oEmpty); end
  endtask

  task automatic test_stream256();
    int ovf_seen = 0, bad = 0;
    do_reset();
    for (int i = 0; i < 256; i++) rMem[i] = 16'hDEAD;
    for (int i = 0; i < 256; i++) begin
      drive(1, 16'(i), 31'(i), 1, 0);
      if (oOvf !== 1'b0) ovf_seen++;
    end
    drive(0, '0, '0, 1, 0);
    drive(0, '0, '0, 1, 0);
    for (int i = 0; i < 256; i++) if (rMem[i] !== 16'(i)) bad++;
    nchk++; if (ovf_seen != 0) begin nerr++; $display("FAIL stream_ovf got=%0d exp=0", ovf_seen); end
    nchk++; if (bad != 0) begin nerr++; $display("FAIL stream_ram bad_words=%0d exp=0", bad); end
  endtask

  task automatic test_overflow();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 16'(100 + i), 31'(i), 0, 0);
      if (oOvf === 1'b1) pulses++;
    end
    nchk++; if (oFull !== 1'b1 || oLevel !== 5'd16) begin nerr++; $display("FAIL ovf_full got=%b/%0d exp=1/16", oFull, oLevel); end
    drive(0, '0, '0, 0, 0);
    if (oOvf === 1'b1) pulses++;
    nchk++; if (pulses != 1) begin nerr++; $display("FAIL ovf_pulses got=%0d exp=1", pulses); end
    for (int k = 0; k < 16; k++) begin
      nchk++;
      if (oMUfiWd !== 16'(100 + k) || oMUfiAdrs[31] !== 1'b1) begin
        nerr++; $display("FAIL ovf_drain k=%0d got=%h/%b exp=%h/1", k, oMUfiWd, oMUfiAdrs[31], 16'(100 + k));
      end
      drive(0, '0, '0, 1, 0);
    end
    nchk++; if (oEmpty !== 1'b1) begin nerr++; $display("FAIL ovf_empty got=%b exp=1", oEmpty); end
  endtask

  task automatic test_full_xfer();
    logic [15:0] exp;
    do_reset();
    for (int i = 0; i < 16; i++) drive(1, 16'(200 + i), 31'(i), 0, 0);
    drive(1, 16'hBEEF, 31'h77, 1, 0);
    nchk++; if (oLevel !== 5'd16 || oOvf !== 1'b0) begin nerr++; $display("FAIL fullx_level got=%0d/%b exp=16/0", oLevel, oOvf); end
    for (int k = 0; k < 16; k++) begin
      exp = (k < 15) ? 16'(201 + k) : 16'hBEEF;
      nchk++; if (oMUfiWd !== exp) begin nerr++; $display("FAIL fullx_order k=%0d got=%h exp=%h", k, oMUfiWd, exp); end
      drive(0, '0, '0, 1, 0);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 16'(300 + i), 31'(i), 0, 0);
    drive(1, 16'hCAFE, 31'h5, 0, 1);
    nchk++; if (oEmpty !== 1'b1 || oMUfiAdrs !== 32'h0 || oLevel !== 5'd0) begin
      nerr++; $display("FAIL flush_clear got=%b/%h/%0d exp=1/0/0", oEmpty, oMUfiAdrs, oLevel); end
    drive(1, 16'hF00D, 31'h6, 1, 0);
    nchk++; if (oEmpty !== 1'b1) begin nerr++; $display("FAIL flush_ignore got=%b exp=1", oEmpty); end
    drive(0, '0, '0, 1, 0);
    nchk++; if (oEmpty !== 1'b1 || oMUfiAdrs !== 32'h0) begin nerr++; $display("FAIL flush_lost got=%b/%h exp=1/0", oEmpty, oMUfiAdrs); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 16'(400 + i), 31'(i), 0, 0);
    iSRST = 1'b1;
    drive(0, '0, '0, 0, 0);
    iSRST = 1'b0;
    nchk++; if ({oMUfiWd, oMUfiAdrs} !== 48'h0) begin nerr++; $display("FAIL rstmid_out got=%h/%h exp=0/0", oMUfiWd, oMUfiAdrs); end
    nchk++; if ({oEmpty, oFull, oOvf, oLevel} !== {3'b100, 5'd0}) begin
      nerr++; $display("FAIL rstmid_flags got=%b exp=10000000", {oEmpty, oFull, oOvf, oLevel}); end
  endtask

`ifdef UFI_WR_FIFO_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 19; i++) drive(1, 16'(i), 31'(i), 0, 0);
    drive(0, '0, '0, 0, 0);
    nchk++; if (oOvfCnt !== 16'd3) begin nerr++; $display("FAIL stats_cnt got=%0d exp=3", oOvfCnt); end
    iSRST = 1'b1;
    drive(0, '0, '0, 0, 0);
    iSRST = 1'b0;
    nchk++; if (oOvfCnt !== 16'd0) begin nerr++; $display("FAIL stats_rst got=%0d exp=0", oOvfCnt); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] ea;
    int rdy_pct;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy_pct = ((c / 300) % 2 == 0) ? 25 : 80;
      iSRST = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 3) != 0, 16'($urandom), 31'($urandom),
            $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 149) == 0);
      iSRST = 1'b0;
      ea = (mq.size() > 0) ? {1'b1, mq[0].adrs} : 32'h0;
      nchk++; if (oLevel !== 5'(mq.size())) begin nerr++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, oLevel, mq.size()); end
      nchk++; if (oFull !== (mq.size() == DEPTH) || oEmpty !== (mq.size() == 0)) begin
        nerr++; $display("FAIL rnd_flags c=%0d got=%b%b exp_size=%0d", c, oFull, oEmpty, mq.size()); end
      nchk++; if (oOvf !== m_ovf) begin nerr++; $display("FAIL rnd_ovf c=%0d got=%b exp=%b", c, oOvf, m_ovf); end
      nchk++; if (oMUfiAdrs !== ea) begin nerr++; $display("FAIL rnd_adrs c=%0d got=%h exp=%h", c, oMUfiAdrs, ea); end
      if (mq.size() > 0) begin
        nchk++; if (oMUfiWd !== mq[0].wd) begin nerr++; $display("FAIL rnd_wd c=%0d got=%h exp=%h", c, oMUfiWd, mq[0].wd); end
      end
`ifdef UFI_WR_FIFO_STATS_EN
      nchk++; if (oOvfCnt !== 16'(m_cnt)) begin nerr++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, oOvfCnt, m_cnt); end
`endif
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_stream256();
    test_overflow();
    test_full_xfer();
    test_flush();
    test_reset_mid();
`ifdef UFI_WR_FIFO_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ufi_wr_fifo.md
UFI_WR_FIFO -- requirements
Module: ufi_wr_fifo

Interface
REQ-001 SHALL have parameter pUfiDqBusWidth, default 16: UFI write-data width.
REQ-002 SHALL have parameter pUfiAdrsBusWidth, default 32: UFI address width; MSB is the command-valid flag.
REQ-003 SHALL have parameter pFifoDepth, default 16, power of two >= 4: buffered entries.
REQ-004 SHALL have port iSCLK  in  1: system clock; single clock domain, all logic on rising edge.
REQ-005 SHALL have port iSRST  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port iWd  in  pUfiDqBusWidth: write data from the producer (MCB CSR path).
REQ-007 SHALL have port iAdrs  in  pUfiAdrsBusWidth-1: target RAM word address.
REQ-008 SHALL have port iWe  in  1: push strobe, one entry per cycle high.
REQ-009 SHALL have port iFlush  in  1: discard all buffered and pending entries.
REQ-010 SHALL have port oMUfiWd  out  pUfiDqBusWidth: UFIB master write data.
REQ-011 SHALL have port oMUfiAdrs  out  pUfiAdrsBusWidth: {valid, address} to UFIB.
REQ-012 SHALL have port iMUfiRdy  in  1: UFIB accept; transfer = valid & iMUfiRdy in the same cycle.
REQ-013 SHALL have ports oFull, oEmpty (out, 1 each) and oLevel (out, log2(pFifoDepth)+1): occupancy.
REQ-014 SHALL have port oOvf  out  1: one-cycle pulse when a push is dropped.

Function
REQ-015 SHALL implement FSM sIdle / sSend / sFlush; sIdle: output invalid, FIFO empty; sSend: output valid.
REQ-016 SHALL move sIdle->sSend the cycle after the first push: push in cycle N gives valid output in cycle N+1.
REQ-017 SHALL hold oMUfiWd/oMUfiAdrs stable while valid and iMUfiRdy low.
REQ-018 SHALL present the next entry in the cycle after a transfer if one is buffered: back-to-back throughput of 1 word/cycle. It SHALL return to sIdle when none is buffered.
REQ-019 SHALL drive oMUfiAdrs to all zeros while not valid.
REQ-020 SHALL count oLevel over buffered entries plus the output register, from 0 to pFifoDepth.
REQ-021 SHALL use pointers that wrap modulo pFifoDepth, with an extra MSB to distinguish full from empty.
REQ-022 SHALL drop a push with oFull high (no state change) and pulse oOvf.
REQ-023 SHALL accept a push and a transfer in the same cycle when full: level unchanged, oOvf low.
REQ-024 SHALL let a push and a transfer in the same cycle when level is 1 bypass the stored word to the output: valid stays high.
REQ-025 SHALL give iFlush priority over push and pop. On iFlush it SHALL enter sFlush for 1 cycle (output invalid, pointers cleared, pushes ignored), then go to sIdle.
REQ-026 SHALL never drop or duplicate a word: order out equals order in.

Reset
REQ-027 SHALL, with iSRST high, put the FSM in sIdle, zero the pointers, drive oMUfiWd=0, oMUfiAdrs=0, oEmpty=1, oFull=0, oLevel=0, oOvf=0. Assertion mid-transfer SHALL abandon the pending word.
REQ-028 SHALL leave the memory array contents unreset; they are don't-care.

Configuration
REQ-029 SHALL, with UFI_WR_FIFO_STATS_EN defined, add output oOvfCnt (16 bits). It counts dropped pushes, saturates at 'hFFFF, and clears on reset and iFlush.
REQ-030 SHALL, with UFI_WR_FIFO_STATS_EN undefined, omit the oOvfCnt port and its logic. All other behaviour SHALL be identical.

Structure
REQ-031 SHALL take the UFI width defaults (16/32) and the valid-bit index constant from the shared ufib_pkg. The FSM state encoding SHALL live in the same package.
REQ-032 SHALL instantiate one sub-module, ufi_fifo_mem: a simple dual-port array with registered write and asynchronous read.

Verification
REQ-033 SHALL cover: reset, then push (iWd='h1234, iAdrs='h10) with iMUfiRdy=1 -> oMUfiAdrs='h8000_0010 and oMUfiWd='h1234 exactly one cycle later, for one cycle.
REQ-034 SHALL cover: 256 consecutive pushes (data=i, adrs=i) with iMUfiRdy=1 and a RAMBlock model -> RAM holds rMem[i]=i for all i, oOvf never high.
REQ-035 SHALL cover: iMUfiRdy=0 with 17 pushes at depth 16 -> oFull=1, oLevel=16, one oOvf pulse. Then Rdy=1 -> words 0..15 drain in order.
REQ-036 SHALL cover: at full, simultaneous push and transfer -> oLevel stays 16, oOvf=0, pushed word emerges last.
REQ-037 SHALL cover: iFlush with 5 entries buffered and a push in the same cycle -> next cycle oEmpty=1, oMUfiAdrs=0, the pushed word is lost.
REQ-038 SHALL cover: iSRST asserted while valid and iMUfiRdy=0 -> all outputs at reset values the next cycle. With UFI_WR_FIFO_STATS_EN, 3 drops -> oOvfCnt=3, then reset -> 0.
